byte_lsu: RTL

BYTE_LSU -- requirements
Module: byte_lsu

---
 rtl/byte_lsu_if.sv | 48 ++++
 rtl/byte_lsu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/byte_lsu_if.sv
// byte_lsu_if
//
// Bundles the request/response handshake and the byte-wide memory port
// of the byte load/store unit.
//
// Signals:
//   req_valid, req_ready      request handshake
//   req_we, req_size          store/load select and access size (0/1/2, 3 illegal)
//   req_unsigned              zero-extend loads when set
//   req_addr [AW], req_wdata  byte address and right-aligned store data
//   rsp_valid                 one-cycle completion pulse
//   rsp_rdata, rsp_err        load result and rejection flag
//   mem_address, mem_data     byte address and write byte to the memory
//   mem_wren                  memory write enable
//   mem_q                     memory read byte, one cycle after its address
//
// Modports:
//   slave  - the load/store unit itself
//   master - the requester plus attached memory (environment side)

interface byte_lsu_if #(
    parameter int AW = 6
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_wren;
    logic [7:0]    mem_q;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/byte_lsu.sv
// byte_lsu
//
// Splits byte/half/word load and store requests into little-endian
// sequential byte accesses on a 2^AW x 8 synchronous-read memory.
// Misaligned requests and size 3 are rejected without touching memory.
//
// Ports:
//   clock  - single clock, rising edge
//   reset  - asynchronous, active-high; clears all state immediately
//   bus    - byte_lsu_if.slave: request/response handshake and memory port

module byte_lsu #(
    parameter int AW = 6
) (
    input  logic        clock,
    input  logic        reset,
    byte_lsu_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic          unsigned_q, unsigned_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [7:0]    mem_data_q, mem_data_d;
    logic          mem_wren_q, mem_wren_d;

    logic          accept;
    logic          req_illegal;
    logic [1:0]    last_idx;
    logic [1:0]    idx_next;
    logic [1:0]    idx_prev;
    logic [31:0]   wdata_shifted;
    logic [31:0]   merged;

    // The response cycle also counts as ready so a back-to-back request
    // can be taken at the edge that closes the response.
    assign accept      = bus.req_valid && (state_q == IDLE || state_q == RESP);
    assign req_illegal = (bus.req_size == 2'd3)
                       || (bus.req_size == 2'd1 && bus.req_addr[0])
                       || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);

    // Index of the final byte: 0, 1 or 3 for byte, half, word.
    assign last_idx      = {size_q[1], size_q[1] | size_q[0]};
    assign idx_next      = idx_q + 2'd1;
    assign idx_prev      = idx_q - 2'd1;
    assign wdata_shifted = wdata_q >> {idx_next, 3'b000};
    // The final load byte arrives in DRAIN; fold it in before extension.
    assign merged        = data_q | ({24'd0, bus.mem_q} << {last_idx, 3'b000});

    // Next-state and datapath decisions for the whole transaction.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        idx_d         = idx_q;
        data_d        = data_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    we_d       = bus.req_we;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    addr_d     = bus.req_addr;
                    wdata_d    = bus.req_wdata;
                    err_d      = req_illegal;
                    idx_d      = 2'd0;
                    data_d     = 32'd0;
                    if (req_illegal) begin
                        // Rejected requests spend one silent cycle so their
                        // response appears one edge after acceptance.
                        state_d = DRAIN;
                    end else begin
                        state_d       = ACCESS;
                        mem_address_d = bus.req_addr;
                        mem_data_d    = bus.req_wdata[7:0];
                        mem_wren_d    = bus.req_we;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                // Byte idx-1 was addressed two edges ago and is on mem_q now.
                if (!we_q && idx_q != 2'd0) begin
                    data_d = data_q | ({24'd0, bus.mem_q} << {idx_prev, 3'b000});
                end
                if (idx_q == last_idx) begin
                    if (we_q) begin
                        state_d     = RESP;
                        rsp_rdata_d = 32'd0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    idx_d         = idx_next;
                    mem_address_d = addr_q + AW'(idx_next);
                    mem_data_d    = wdata_shifted[7:0];
                    mem_wren_d    = we_q;
                end
            end

            DRAIN: begin
                state_d = RESP;
                if (err_q) begin
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                end else begin
                    rsp_err_d = 1'b0;
                    case (size_q)
                        2'd0:    rsp_rdata_d = unsigned_q ? {24'd0, merged[7:0]}
                                                          : {{24{merged[7]}}, merged[7:0]};
                        2'd1:    rsp_rdata_d = unsigned_q ? {16'd0, merged[15:0]}
                                                          : {{16{merged[15]}}, merged[15:0]};
                        default: rsp_rdata_d = merged;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // All registers clear asynchronously so an aborted store stops writing at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'd0;
            unsigned_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            err_q         <= 1'b0;
            idx_q         <= 2'd0;
            data_q        <= 32'd0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= 8'd0;
            mem_wren_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            idx_q         <= idx_d;
            data_q        <= data_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
        end
    end

    assign bus.req_ready   = (state_q == IDLE) || (state_q == RESP);
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_wren    = mem_wren_q;

endmodule
